// File: rtl/acq_trigger_ctrl.sv
// acq_trigger_ctrl: oscilloscope acquisition sequencer.
// Generates the frame RAM write address/enable from the sample strobe. It
// fills a pre-trigger window and waits for a level/slope trigger on channel
// A or B (or an auto-mode timeout). It then writes the post-trigger samples
// and freezes the frame until the display path reports it has been drawn.
//
// Strobe semantics: sample_en is a one-cycle qualifier. A sample is written
// at wr_addr on every sys_clk edge where wren=1, and wr_addr advances on that
// same edge. There is no backpressure; samples arriving while wren=0 are
// simply not stored.
//
// PRE_TRIG must be at least 1 and less than FRAME_LEN.
module acq_trigger_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int FRAME_LEN = 400,
  parameter int PRE_TRIG  = 100,
  parameter int AUTO_TMO  = 4000
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [7:0]        adc_db_a,
  input  logic [7:0]        adc_db_b,
  input  logic              trig_src,
  input  logic              trig_slope,
  input  logic [7:0]        trig_level,
  input  logic [1:0]        run_mode,
  input  logic              arm,
  input  logic              disp_done,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wren,
  output logic [ADDR_W-1:0] frame_start,
  output logic              frame_ready,
  output logic              trig_hit,
  output logic [2:0]        acq_state
);

  // Number of writes after the trigger sample that complete the frame.
  localparam int POST_LEN = FRAME_LEN - PRE_TRIG - 1;
  // With PRE_TRIG = FRAME_LEN-1 the trigger sample itself closes the frame.
  localparam bit NO_POST  = (POST_LEN == 0);
  localparam int TMO_W    = $clog2(AUTO_TMO + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] PRE_A     = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] BACK_A    = ADDR_W'(FRAME_LEN - PRE_TRIG);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(NO_POST ? 0 : POST_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(AUTO_TMO);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(AUTO_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [7:0]        prev_a;
  logic [7:0]        prev_b;

  logic              mode_single;
  logic              mode_auto;
  logic [7:0]        cur_smp;
  logic [7:0]        prev_smp;
  logic              rise_hit;
  logic              fall_hit;
  logic              trig_fire;
  logic              tmo_fire;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] start_next;

  // Write enable is combinational so the RAM sees it in the strobe cycle.
  assign wren = sample_en && (state == S_PRE || state == S_WAIT || state == S_POST);
  assign acq_state = state;

  // Mode decode; run_mode 3 behaves as normal.
  assign mode_single = (run_mode == 2'd2);
  assign mode_auto   = (run_mode == 2'd0);

  // Trigger comparator on the selected channel against its previous sample.
  always_comb begin
    cur_smp   = trig_src ? adc_db_b : adc_db_a;
    prev_smp  = trig_src ? prev_b : prev_a;
    rise_hit  = (prev_smp < trig_level) && (cur_smp >= trig_level);
    fall_hit  = (prev_smp > trig_level) && (cur_smp <= trig_level);
    trig_fire = trig_slope ? fall_hit : rise_hit;
    // tmo_cnt counts strobes already seen in WAIT_TRIG; this strobe is the next one.
    tmo_fire  = mode_auto && (tmo_cnt >= TMO_LAST);
  end

  // Circular address arithmetic: next write address and oldest-sample address.
  always_comb begin
    addr_next  = (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
    start_next = (wr_addr >= PRE_A) ? (wr_addr - PRE_A) : (wr_addr + BACK_A);
  end

  // Sequencer: state, address, counters, sample history and registered flags.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wr_addr     <= '0;
      frame_start <= '0;
      frame_ready <= 1'b0;
      trig_hit    <= 1'b0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      tmo_cnt     <= '0;
      prev_a      <= '0;
      prev_b      <= '0;
    end else begin
      if (wren) begin
        wr_addr <= addr_next;
        prev_a  <= adc_db_a;
        prev_b  <= adc_db_b;
      end
      case (state)
        S_IDLE: begin
          // Leaving IDLE consumes no sample: wren is low in this state.
          if (mode_single ? arm : sample_en) begin
            state   <= S_PRE;
            pre_cnt <= '0;
          end
        end
        S_PRE: begin
          if (sample_en) begin
            if (pre_cnt == PRE_LAST) begin
              state   <= S_WAIT;
              tmo_cnt <= '0;
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (sample_en) begin
            // Counts in every mode so a switch to auto continues the count.
            if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
            if (trig_fire || tmo_fire) begin
              frame_start <= start_next;
              trig_hit    <= trig_fire;   // a real trigger wins a tie
              post_cnt    <= '0;
              if (NO_POST) begin
                state       <= S_HOLD;
                frame_ready <= 1'b1;
              end else begin
                state <= S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (sample_en) begin
            if (post_cnt == POST_LAST) begin
              state       <= S_HOLD;
              frame_ready <= 1'b1;
            end else begin
              post_cnt <= post_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (disp_done) begin
            frame_ready <= 1'b0;
            pre_cnt     <= '0;
            state       <= mode_single ? S_IDLE : S_PRE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// tb_acq_trigger_ctrl: scenario bench for the acquisition sequencer.
// A stream of selected-channel samples is kept in an array; a frame model
// scans it for the first trigger or timeout after the pre-trigger window and
// derives write count, first/last address, frame_start and trig_hit.
module tb_acq_trigger_ctrl;

  localparam int FL   = 400;
  localparam int PT   = 100;
  localparam int TMO  = 4000;
  localparam int POST = FL - PT - 1;
  localparam int NEVER = 32'h7fff_ffff;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       sample_en;
  logic [7:0] adc_db_a;
  logic [7:0] adc_db_b;
  logic       trig_src;
  logic       trig_slope;
  logic [7:0] trig_level;
  logic [1:0] run_mode;
  logic       arm;
  logic       disp_done;
  logic [8:0] wr_addr;
  logic       wren;
  logic [8:0] frame_start;
  logic       frame_ready;
  logic       trig_hit;
  logic [2:0] acq_state;

  int checks = 0;
  int failures = 0;

  int stream [0:9999];
  int model_addr;

  // observed frame
  int obs_writes, obs_first, obs_last, obs_breaks;
  bit obs_ready;
  // expected frame
  int exp_k, exp_writes, exp_first, exp_last, exp_fs;
  bit exp_hit;

  acq_trigger_ctrl #(.ADDR_W(9), .FRAME_LEN(FL), .PRE_TRIG(PT), .AUTO_TMO(TMO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .sample_en(sample_en),
    .adc_db_a(adc_db_a), .adc_db_b(adc_db_b), .trig_src(trig_src),
    .trig_slope(trig_slope), .trig_level(trig_level), .run_mode(run_mode),
    .arm(arm), .disp_done(disp_done), .wr_addr(wr_addr), .wren(wren),
    .frame_start(frame_start), .frame_ready(frame_ready), .trig_hit(trig_hit),
    .acq_state(acq_state)
  );

  // clock / reset
  always #20 sys_clk = ~sys_clk;

  task automatic apply_reset();
    rst_n = 1'b0; sample_en = 1'b0; adc_db_a = '0; adc_db_b = '0;
    arm = 1'b0; disp_done = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    model_addr = 0;
    @(posedge sys_clk); #1;
  endtask

  // driver: one strobe (one cycle high, one low); starts and ends at posedge+1
  task automatic strobe(input logic [7:0] a, input logic [7:0] b,
                        output logic w, output logic [8:0] ad);
    sample_en = 1'b1; adc_db_a = a; adc_db_b = b;
    @(negedge sys_clk); w = wren; ad = wr_addr;
    @(posedge sys_clk); #1 sample_en = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  task automatic pulse_disp_done();
    disp_done = 1'b1; @(posedge sys_clk); #1 disp_done = 1'b0;
  endtask

  // driver: feeds stream[] on the selected channel until frame_ready or n_max strobes
  task automatic drive_frame(input int base_mode, input int auto_from, input int n_max);
    logic w; logic [8:0] ad; logic [7:0] a, b;
    obs_writes = 0; obs_breaks = 0; obs_ready = 0; obs_first = -1; obs_last = -1;
    for (int i = 0; i < n_max && !obs_ready; i++) begin
      run_mode = (i >= auto_from) ? 2'd0 : 2'(base_mode);
      a = trig_src ? 8'($urandom) : 8'(stream[i]);
      b = trig_src ? 8'(stream[i]) : 8'($urandom);
      strobe(a, b, w, ad);
      if (w) begin
        if (obs_writes != 0 && int'(ad) != (obs_last + 1) % FL) obs_breaks++;
        if (obs_writes == 0) obs_first = int'(ad);
        obs_last = int'(ad);
        obs_writes++;
      end
      if (frame_ready) obs_ready = 1;
    end
  endtask

  // model: first trigger/timeout index after the pre-trigger window
  task automatic exp_frame(input int base_mode, input int auto_from);
    exp_k = -1; exp_hit = 0;
    for (int k = PT; k < 9999 && exp_k < 0; k++) begin
      int p = stream[k-1];
      int c = stream[k];
      bit fire = trig_slope ? (p > int'(trig_level) && c <= int'(trig_level))
                            : (p < int'(trig_level) && c >= int'(trig_level));
      bit is_auto = (k >= auto_from) || (base_mode == 0);
      if (fire) begin exp_k = k; exp_hit = 1; end
      else if (is_auto && (k - PT + 1) >= TMO) begin exp_k = k; exp_hit = 0; end
    end
    exp_writes = exp_k + POST + 1;
    exp_first  = model_addr;
    exp_last   = (model_addr + exp_writes - 1) % FL;
    exp_fs     = (model_addr + exp_k + FL - PT) % FL;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 10000; i++) stream[i] = i % 256;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 10000; i++) stream[i] = v;
  endtask

  task automatic test_reset();
    logic w; logic [8:0] ad; int bad;
    rst_n = 1'b0; sample_en = 1'b1; run_mode = 2'd0; arm = 1'b0; disp_done = 1'b0;
    #5;
    if (wr_addr !== 9'd0) begin $display("FAIL reset_addr got=%0d exp=0", wr_addr); failures++; end checks++;
    if (wren !== 1'b0) begin $display("FAIL reset_wren got=%0b exp=0", wren); failures++; end checks++;
    if (frame_start !== 9'd0) begin $display("FAIL reset_fs got=%0d exp=0", frame_start); failures++; end checks++;
    if ({frame_ready, trig_hit} !== 2'b00) begin $display("FAIL reset_flags got=%b exp=00", {frame_ready, trig_hit}); failures++; end checks++;
    apply_reset();
    // single mode without arm: no writes at all
    run_mode = 2'd2; bad = 0;
    for (int i = 0; i < 20; i++) begin strobe(8'($urandom), 8'($urandom), w, ad); if (w !== 1'b0) bad++; end
    if (bad != 0) begin $display("FAIL idle_no_write got=%0d writes exp=0", bad); failures++; end checks++;
  endtask

  task automatic test_auto_ramp();
    logic w; logic [8:0] ad;
    apply_reset();
    trig_src = 0; trig_slope = 0; trig_level = 8'd128; run_mode = 2'd0;
    fill_ramp();
    strobe(8'd0, 8'd0, w, ad);   // leaves IDLE without writing
    if (w !== 1'b0) begin $display("FAIL ramp_idle_exit got=%0b exp=0", w); failures++; end checks++;
    exp_frame(0, NEVER);
    drive_frame(0, NEVER, exp_writes + 20);
    if (obs_writes != exp_writes) begin $display("FAIL ramp_writes got=%0d exp=%0d", obs_writes, exp_writes); failures++; end checks++;
    if (obs_first != exp_first || obs_last != exp_last) begin $display("FAIL ramp_span got=%0d..%0d exp=%0d..%0d", obs_first, obs_last, exp_first, exp_last); failures++; end checks++;
    if (obs_breaks != 0) begin $display("FAIL ramp_seq got=%0d exp=0", obs_breaks); failures++; end checks++;
    if (frame_start !== 9'(exp_fs)) begin $display("FAIL ramp_fs got=%0d exp=%0d", frame_start, exp_fs); failures++; end checks++;
    if ({frame_ready, trig_hit} !== {1'b1, exp_hit}) begin $display("FAIL ramp_flags got=%b exp=%b", {frame_ready, trig_hit}, {1'b1, exp_hit}); failures++; end checks++;
  endtask

  task automatic test_normal_then_auto();
    logic w; logic [8:0] ad;
    apply_reset();
    trig_src = 0; trig_slope = 0; trig_level = 8'd128; run_mode = 2'd1;
    fill_const(50);
    strobe(8'd50, 8'd0, w, ad);
    exp_frame(1, 1000);
    drive_frame(1, 1000, exp_writes + 20);
    if (obs_writes != exp_writes) begin $display("FAIL n2a_writes got=%0d exp=%0d", obs_writes, exp_writes); failures++; end checks++;
    if (obs_breaks != 0 || obs_last != exp_last) begin $display("FAIL n2a_seq got=%0d,%0d exp=0,%0d", obs_breaks, obs_last, exp_last); failures++; end checks++;
    if (frame_start !== 9'(exp_fs)) begin $display("FAIL n2a_fs got=%0d exp=%0d", frame_start, exp_fs); failures++; end checks++;
    if ({frame_ready, trig_hit} !== {1'b1, exp_hit}) begin $display("FAIL n2a_flags got=%b exp=%b", {frame_ready, trig_hit}, {1'b1, exp_hit}); failures++; end checks++;
  endtask

  task automatic test_single();
    logic w; logic [8:0] ad; int bad;
    apply_reset();
    trig_src = 1; trig_slope = 1; trig_level = 8'd100; run_mode = 2'd2;
    for (int i = 0; i < 10000; i++) stream[i] = (i < 150) ? int'($urandom_range(101, 255)) : int'($urandom_range(0, 255));
    stream[150] = $urandom_range(0, 100);
    arm = 1'b1; @(posedge sys_clk); #1 arm = 1'b0;
    exp_frame(2, NEVER);
    drive_frame(2, NEVER, exp_writes + 20);
    if (obs_writes != exp_writes || obs_breaks != 0) begin $display("FAIL single_writes got=%0d/%0d exp=%0d/0", obs_writes, obs_breaks, exp_writes); failures++; end checks++;
    if (frame_start !== 9'(exp_fs)) begin $display("FAIL single_fs got=%0d exp=%0d", frame_start, exp_fs); failures++; end checks++;
    if ({frame_ready, trig_hit} !== 2'b11) begin $display("FAIL single_flags got=%b exp=11", {frame_ready, trig_hit}); failures++; end checks++;
    model_addr = (model_addr + exp_writes) % FL;
    pulse_disp_done();
    if (frame_ready !== 1'b0) begin $display("FAIL single_release got=%0b exp=0", frame_ready); failures++; end checks++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin strobe(8'($urandom), 8'($urandom), w, ad); if (w !== 1'b0) bad++; end
    if (bad != 0 || wr_addr !== 9'(model_addr)) begin $display("FAIL single_rearm got=%0d,%0d exp=0,%0d", bad, wr_addr, model_addr); failures++; end checks++;
  endtask

  task automatic test_wrap();
    logic w; logic [8:0] ad;
    apply_reset();
    trig_src = 0; trig_slope = 0; trig_level = 8'd128; run_mode = 2'd1;
    fill_const(50);
    stream[430] = 200;   // trigger written at address 30
    strobe(8'd50, 8'd0, w, ad);
    exp_frame(1, NEVER);
    drive_frame(1, NEVER, exp_writes + 20);
    if (frame_start !== 9'd330) begin $display("FAIL wrap_fs got=%0d exp=330", frame_start); failures++; end checks++;
    if (obs_last != 329 || obs_breaks != 0) begin $display("FAIL wrap_last got=%0d/%0d exp=329/0", obs_last, obs_breaks); failures++; end checks++;
    if (obs_writes != exp_writes) begin $display("FAIL wrap_writes got=%0d exp=%0d", obs_writes, exp_writes); failures++; end checks++;
  endtask

  task automatic test_trig_tmo_tie();
    logic w; logic [8:0] ad;
    apply_reset();
    trig_src = 0; trig_slope = 0; trig_level = 8'd128; run_mode = 2'd0;
    fill_const(50);
    stream[PT + TMO - 1] = 200;   // crossing on the timeout strobe
    strobe(8'd50, 8'd0, w, ad);
    exp_frame(0, NEVER);
    drive_frame(0, NEVER, exp_writes + 20);
    if (obs_writes != exp_writes) begin $display("FAIL tie_writes got=%0d exp=%0d", obs_writes, exp_writes); failures++; end checks++;
    if ({frame_ready, trig_hit} !== 2'b11) begin $display("FAIL tie_flags got=%b exp=11", {frame_ready, trig_hit}); failures++; end checks++;
  endtask

  task automatic test_reset_in_post();
    logic w; logic [8:0] ad;
    apply_reset();
    trig_src = 0; trig_slope = 0; trig_level = 8'd128; run_mode = 2'd0;
    fill_ramp();
    strobe(8'd0, 8'd0, w, ad);
    exp_frame(0, NEVER);
    drive_frame(0, NEVER, exp_k + 150);
    if (obs_ready || trig_hit !== 1'b1) begin $display("FAIL post_mid got=%0b,%0b exp=0,1", obs_ready, trig_hit); failures++; end checks++;
    sample_en = 1'b1; #7 rst_n = 1'b0; #2;
    if ({wren, frame_ready, trig_hit} !== 3'b000 || wr_addr !== 9'd0 || frame_start !== 9'd0) begin
      $display("FAIL post_reset got=%b,%0d,%0d exp=000,0,0", {wren, frame_ready, trig_hit}, wr_addr, frame_start); failures++;
    end checks++;
    sample_en = 1'b0;
    @(posedge sys_clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_hold();
    logic w; logic [8:0] ad; int bad;
    apply_reset();
    trig_src = 0; trig_slope = 0; trig_level = 8'd128; run_mode = 2'd0;
    fill_ramp();
    strobe(8'd0, 8'd0, w, ad);
    exp_frame(0, NEVER);
    drive_frame(0, NEVER, exp_writes + 20);
    model_addr = (model_addr + exp_writes) % FL;
    bad = 0;
    for (int i = 0; i < 50; i++) begin strobe(8'($urandom), 8'($urandom), w, ad); if (w !== 1'b0 || ad !== 9'(model_addr)) bad++; end
    if (bad != 0 || frame_ready !== 1'b1) begin $display("FAIL hold_frozen got=%0d,%0b exp=0,1", bad, frame_ready); failures++; end checks++;
    // crossing at index 50 falls in the pre-trigger window and must be ignored
    trig_level = 8'd50;
    pulse_disp_done();
    exp_frame(0, NEVER);
    drive_frame(0, NEVER, exp_writes + 20);
    if (obs_first != exp_first || obs_writes != exp_writes) begin $display("FAIL hold_refill got=%0d/%0d exp=%0d/%0d", obs_first, obs_writes, exp_first, exp_writes); failures++; end checks++;
    if (frame_start !== 9'(exp_fs)) begin $display("FAIL hold_fs got=%0d exp=%0d", frame_start, exp_fs); failures++; end checks++;
  endtask

  task automatic test_back_to_back();
    logic w; logic [8:0] ad;
    apply_reset();
    run_mode = 2'd0;
    strobe(8'd0, 8'd0, w, ad);
    for (int f = 0; f < 4; f++) begin
      trig_src = 1'($urandom); trig_slope = 1'($urandom);
      trig_level = 8'($urandom_range(30, 220));
      for (int i = 0; i < 10000; i++) stream[i] = $urandom_range(0, 255);
      exp_frame(0, NEVER);
      drive_frame(0, NEVER, exp_writes + 20);
      if (obs_writes != exp_writes || obs_first != exp_first || obs_breaks != 0) begin
        $display("FAIL b2b_writes f=%0d got=%0d@%0d/%0d exp=%0d@%0d/0", f, obs_writes, obs_first, obs_breaks, exp_writes, exp_first); failures++;
      end checks++;
      if (frame_start !== 9'(exp_fs) || trig_hit !== exp_hit) begin
        $display("FAIL b2b_frame f=%0d got=%0d,%0b exp=%0d,%0b", f, frame_start, trig_hit, exp_fs, exp_hit); failures++;
      end checks++;
      model_addr = (model_addr + exp_writes) % FL;
      pulse_disp_done();
    end
  endtask

  initial begin
    trig_src = 0; trig_slope = 0; trig_level = 8'd128; run_mode = 2'd0;
    test_reset();
    test_auto_ramp();
    test_normal_then_auto();
    test_single();
    test_wrap();
    test_trig_tmo_tie();
    test_reset_in_post();
    test_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
